cordic_sincos_unit: RTL and testbench

- Parametrised iterative CORDIC rotation engine. One signed fixed-point angle in; sine and cosine of that angle out together.
- Next generation of the single-output sin/cos instruction path:
  - generic width, fraction bits and iteration count;
  - full-circle quadrant folding;
  - range-error reporting;
  - busy/done handshake.
- Sits between fp_to_fixed and fixed_to_fp in the custom-instruction datapath.

---
 rtl/cordic_sincos_unit.sv | 170 +++++++++++++++++
 tb/tb_cordic_sincos_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_unit.sv
// Iterative CORDIC rotation engine: one signed fixed-point angle in, sine and cosine out.
// Full-circle quadrant folding, range-error flag and busy/done handshake, all gated by clk_en.
module cordic_sincos_unit #(
   parameter int WIDTH      = 27,
   parameter int FRAC_BITS  = 24,
   parameter int ITERATIONS = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic [WIDTH-1:0] theta_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] sin_out,
   output logic [WIDTH-1:0] cos_out
);
   localparam int ZW = WIDTH + 2;
   localparam int IW = $clog2(ITERATIONS);
   localparam int SH = 32 - FRAC_BITS;

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_FINISH} state_t;

   // Constants are stored with 32 fraction bits and rounded down to FRAC_BITS.
   function automatic logic [63:0] rnd32(input logic [63:0] v);
      return (v + ((64'd1 << SH) >> 1)) >> SH;
   endfunction

   function automatic logic [63:0] atan32(input int i);
      case (i)
         0:       atan32 = 64'hC90F_DAA2;
         1:       atan32 = 64'h76B1_9C16;
         2:       atan32 = 64'h3EB6_EBF2;
         3:       atan32 = 64'h1FD5_BA9B;
         4:       atan32 = 64'h0FFA_ADDC;
         5:       atan32 = 64'h07FF_556F;
         6:       atan32 = 64'h03FF_EAAB;
         7:       atan32 = 64'h01FF_FD55;
         8:       atan32 = 64'h00FF_FFAB;
         9:       atan32 = 64'h007F_FFF5;
         10:      atan32 = 64'h003F_FFFF;
         default: atan32 = (i < 32) ? (64'd1 << (32 - i)) : 64'd0;
      endcase
   endfunction

   localparam logic signed [ZW-1:0] C_PI      = ZW'(rnd32(64'h3_243F_6A89));
   localparam logic signed [ZW-1:0] C_HALF_PI = ZW'(rnd32(64'h1_921F_B544));
   localparam logic signed [ZW-1:0] C_K       = ZW'(rnd32(64'h0_9B74_EDA8));
   localparam logic signed [ZW-1:0] C_ONE     = ZW'(64'd1 << FRAC_BITS);
   localparam logic [IW-1:0]        LAST_ITER = IW'(ITERATIONS - 1);

   function automatic logic [WIDTH-1:0] sat(input logic signed [ZW-1:0] v);
      if (v > C_ONE)  return WIDTH'(C_ONE);
      if (v < -C_ONE) return WIDTH'(-C_ONE);
      return v[WIDTH-1:0];
   endfunction

   state_t               r_state, w_next;
   logic signed [ZW-1:0] r_x, r_y, r_z;
   logic [IW-1:0]        r_iter;
   logic                 r_neg, r_busy, r_done, r_err;
   logic [WIDTH-1:0]     r_sin, r_cos;

   logic signed [ZW-1:0] w_theta, w_fold_z, w_atan, w_x_sh, w_y_sh, w_x_fin, w_y_fin;
   logic                 w_fold_neg, w_over, w_accept;

   assign w_theta = {{2{theta_in[WIDTH-1]}}, theta_in};
   assign w_over  = (w_theta > C_PI) || (w_theta < -C_PI);
   assign w_atan  = ZW'(rnd32(atan32(int'(r_iter))));
   assign w_x_sh  = r_x >>> r_iter;
   assign w_y_sh  = r_y >>> r_iter;
   assign w_x_fin = r_neg ? -r_x : r_x;
   assign w_y_fin = r_neg ? -r_y : r_y;

   // Outer half-planes rotate by pi into the CORDIC convergence range; the result sign flips.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_fold_z   = w_theta;
      w_fold_neg = 1'b0;
      if (w_theta > C_HALF_PI) begin
         w_fold_z   = w_theta - C_PI;
         w_fold_neg = 1'b1;
      end else if (w_theta < -C_HALF_PI) begin
         w_fold_z   = w_theta + C_PI;
         w_fold_neg = 1'b1;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE:   if (start && !w_over) begin
                      w_accept = 1'b1;
                      w_next   = S_ROTATE;
                   end
         S_ROTATE: if (r_iter == LAST_ITER) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_state <= S_IDLE;
      else if (clk_en) r_state <= w_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_iter <= '0;
         r_neg  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_sin  <= '0;
         r_cos  <= '0;
      end else if (clk_en) begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && w_over) begin
                  r_err  <= 1'b1;
                  r_sin  <= '0;
                  r_cos  <= '0;
                  r_done <= 1'b1;
               end else if (w_accept) begin
                  r_x    <= C_K;
                  r_y    <= '0;
                  r_z    <= w_fold_z;
                  r_neg  <= w_fold_neg;
                  r_iter <= '0;
                  r_err  <= 1'b0;
                  r_busy <= 1'b1;
               end
            end
            S_ROTATE: begin
               if (!r_z[ZW-1]) begin
                  r_x <= r_x - w_y_sh;
                  r_y <= r_y + w_x_sh;
                  r_z <= r_z - w_atan;
               end else begin
                  r_x <= r_x + w_y_sh;
                  r_y <= r_y - w_x_sh;
                  r_z <= r_z + w_atan;
               end
               if (r_iter != LAST_ITER) r_iter <= r_iter + IW'(1);
            end
            S_FINISH: begin
               r_cos  <= sat(w_x_fin);
               r_sin  <= sat(w_y_fin);
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign sin_out = r_sin;
   assign cos_out = r_cos;

endmodule

// File: tb/tb_cordic_sincos_unit.sv
// Directed bench for cordic_sincos_unit: hand-computed sin/cos at 24 fraction bits, +/-26 LSB.
// PI at this precision is round(pi*2^24) = 0x3243F6B; anything beyond it is a range error.
module tb_cordic_sincos_unit;
   localparam int TOL     = 26;
   localparam int ONE     = 'h1000000;
   localparam int SIN30   = 8388608;
   localparam int COS30   = 14529495;
   localparam int R45     = 11863283;
   localparam int SIN1    = 14117540;
   localparam int COS1    = 9064768;
   localparam int PI_Q    = 'h3243F6B;
   localparam int HALF_PI = 'h1921FB5;
   localparam int TH30    = 'h860A92;
   localparam int TH1RAD  = 'h1000000;

   logic        clk, reset, clk_en, start, busy, done, err;
   logic [26:0] theta_in, sin_out, cos_out;
   int          n_cmp = 0;
   int          n_bad = 0;

   cordic_sincos_unit #(.WIDTH(27), .FRAC_BITS(24), .ITERATIONS(24)) dut (
      .clk     (clk),
      .reset   (reset),
      .clk_en  (clk_en),
      .start   (start),
      .theta_in(theta_in),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .sin_out (sin_out),
      .cos_out (cos_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
      longint diff;
      n_cmp++;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic check_outputs(input string tag, input int s_exp, input int c_exp,
                                input logic e_exp, input int tol);
      check({tag, " sin"}, $signed(sin_out), s_exp, tol);
      check({tag, " cos"}, $signed(cos_out), c_exp, tol);
      check({tag, " err"}, err, e_exp, 0);
   endtask

   // Issue one start at a negedge; return edges from acceptance to done and busy samples seen.
   task automatic run_op(input int th, output int cyc, output int nbusy);
      theta_in = 27'(th);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      nbusy = 0;
      while (!done && cyc < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic normal_op(input string tag, input int th, input int s_exp, input int c_exp);
      int cyc, nb;
      run_op(th, cyc, nb);
      check({tag, " latency"}, cyc, 25, 0);
      check({tag, " busy cycles"}, nb, 25, 0);
      check_outputs(tag, s_exp, c_exp, 1'b0, TOL);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int cyc, nb, nd;
      reset    = 1'b1;
      clk_en   = 1'b1;
      start    = 1'b0;
      theta_in = '0;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 0, 0);
      check("reset done", done, 0, 0);
      check_outputs("reset", 0, 0, 1'b0, 0);
      reset = 1'b0;
      @(negedge clk);

      normal_op("zero", 0, 0, ONE);
      check("zero done high", done, 1, 0);
      @(negedge clk);
      check("zero done pulse", done, 0, 0);

      normal_op("pi/2", HALF_PI, ONE, 0);
      normal_op("-pi/2", -HALF_PI, -ONE, 0);
      normal_op("-3pi/4", -'h25B2F90, -R45, -R45);
      normal_op("pi/6", TH30, SIN30, COS30);

      run_op(PI_Q + 1, cyc, nb);
      check("pi+1 latency", cyc, 0, 0);
      check("pi+1 busy", busy, 0, 0);
      check_outputs("pi+1", 0, 0, 1'b1, 0);
      @(negedge clk);
      check("pi+1 done pulse", done, 0, 0);
      check("pi+1 err held", err, 1, 0);

      run_op(-PI_Q - 1, cyc, nb);
      check("-pi-1 latency", cyc, 0, 0);
      check_outputs("-pi-1", 0, 0, 1'b1, 0);

      normal_op("pi", PI_Q, 0, -ONE);
      normal_op("-pi", -PI_Q, 0, -ONE);
      normal_op("pi-lsb", PI_Q - 1, 0, -ONE);

      // clk_en gated for 3 cycles mid-rotation and 3 more while done is high.
      theta_in = 27'(TH30);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      repeat (5) begin @(negedge clk); cyc++; end
      clk_en = 1'b0;
      repeat (3) begin @(negedge clk); cyc++; end
      check("gated busy held", busy, 1, 0);
      clk_en = 1'b1;
      while (!done && cyc < 100) begin @(negedge clk); cyc++; end
      check("gated latency", cyc, 28, 0);
      check_outputs("gated", SIN30, COS30, 1'b0, TOL);
      clk_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("gated done held", done, 1, 0);
      end
      clk_en = 1'b1;
      @(negedge clk);
      check("gated done cleared", done, 0, 0);

      // Starts while busy are dropped; a start on the done cycle is accepted.
      theta_in = 27'(-TH30);
      start    = 1'b1;
      @(negedge clk);
      cyc = 0;
      start = 1'b0;
      while (!done && cyc < 100) begin
         start = (cyc == 5 || cyc == 24);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("busy-start latency", cyc, 25, 0);
      check_outputs("busy-start", -SIN30, COS30, 1'b0, TOL);
      theta_in = 27'(TH1RAD);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      check("back-to-back done cleared", done, 0, 0);
      check("back-to-back busy", busy, 1, 0);
      while (!done && cyc < 100) begin @(negedge clk); cyc++; end
      check("back-to-back latency", cyc, 25, 0);
      check_outputs("back-to-back", SIN1, COS1, 1'b0, TOL);

      // Asynchronous reset between clock edges during iteration 10.
      theta_in = 27'(HALF_PI);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async rst busy", busy, 0, 0);
      check("async rst done", done, 0, 0);
      check_outputs("async rst", 0, 0, 1'b0, 0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("no done after abort", nd, 0, 0);
      normal_op("after reset", TH1RAD, SIN1, COS1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
